// File: rtl/alu_arbiter.sv
// Two-port arbiter/sequencer sharing one external combinational 32-bit ALU.
// Accepts one operation at a time, registers operands, captures result/flags, returns them with backpressure.
module alu_arbiter #(
    parameter bit PRIORITY_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_flags,
    output logic        busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_id_q, grant_id_d;
    logic [31:0] alu_a_q, alu_a_d;
    logic [31:0] alu_b_q, alu_b_d;
    logic [2:0]  alu_op_q, alu_op_d;
    logic [31:0] rsp_result_q, rsp_result_d;
    logic [3:0]  rsp_flags_q, rsp_flags_d;
    logic        rsp0_valid_q, rsp0_valid_d;
    logic        rsp1_valid_q, rsp1_valid_d;
    logic        busy_q, busy_d;

    logic        gnt0_s, gnt1_s;
    logic        accept_s;
    logic        rsp_fire_s;
    logic        arith_s;

    // Arbitration winner; in round-robin a tie goes to the port that did not win last.
    always_comb begin
        gnt0_s = 1'b0;
        if (PRIORITY_MODE == 1'b1) begin
            gnt0_s = req0_valid;
        end else if (req0_valid && req1_valid) begin
            gnt0_s = last_grant_q;
        end else begin
            gnt0_s = req0_valid;
        end
        gnt1_s = req1_valid && !gnt0_s;
    end

    assign req0_ready = (state_q == ST_IDLE) && gnt0_s;
    assign req1_ready = (state_q == ST_IDLE) && gnt1_s;
    assign accept_s   = req0_ready || req1_ready;
    assign rsp_fire_s = grant_id_q ? (rsp1_valid_q && rsp1_ready) : (rsp0_valid_q && rsp0_ready);
    assign arith_s    = (alu_op_q == OP_ADD) || (alu_op_q == OP_SUB);

    // Next-state and next-register values for the IDLE/EXEC/RESP sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        rsp0_valid_d = rsp0_valid_q;
        rsp1_valid_d = rsp1_valid_q;
        busy_d       = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d    = ST_EXEC;
                    busy_d     = 1'b1;
                    grant_id_d = gnt1_s;
                    alu_a_d    = gnt1_s ? req1_a  : req0_a;
                    alu_b_d    = gnt1_s ? req1_b  : req0_b;
                    alu_op_d   = gnt1_s ? req1_op : req0_op;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d      = ST_RESP;
                rsp_result_d = alu_result;
                // Carry/overflow only carry meaning for ADD and SUB.
                rsp_flags_d  = {alu_overflow && arith_s, alu_negative, alu_zero, alu_carry && arith_s};
                rsp0_valid_d = !grant_id_q;
                rsp1_valid_d = grant_id_q;
            end
            ST_RESP: begin
                if (rsp_fire_s) begin
                    state_d      = ST_IDLE;
                    rsp0_valid_d = 1'b0;
                    rsp1_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    last_grant_d = grant_id_q;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d      = ST_IDLE;
                rsp0_valid_d = 1'b0;
                rsp1_valid_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            alu_a_q      <= 32'd0;
            alu_b_q      <= 32'd0;
            alu_op_q     <= 3'b000;
            rsp_result_q <= 32'd0;
            rsp_flags_q  <= 4'd0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a round-robin instance and a fixed-priority instance share stimulus.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp0_ready, rsp1_ready;

    logic        r_req0_ready, r_req1_ready, r_rsp0_valid, r_rsp1_valid, r_busy;
    logic [31:0] r_alu_a, r_alu_b, r_alu_result, r_rsp_result;
    logic [2:0]  r_alu_op;
    logic [3:0]  r_rsp_flags;
    logic        r_alu_carry, r_alu_zero, r_alu_negative, r_alu_overflow;

    logic        p_req0_ready, p_req1_ready, p_rsp0_valid, p_rsp1_valid, p_busy;
    logic [31:0] p_alu_a, p_alu_b, p_alu_result, p_rsp_result;
    logic [2:0]  p_alu_op;
    logic [3:0]  p_rsp_flags;
    logic        p_alu_carry, p_alu_zero, p_alu_negative, p_alu_overflow;

    int errors = 0;
    int checks = 0;

    // Environment ALU; carry/overflow are deliberately set for logic/shift ops so masking is visible.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        case (op)
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; c = s[32];
                          v = (a[31] == b[31]) && (r[31] != a[31]); end
            3'b001: begin r = a - b; c = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
            3'b010: begin r = a & b; c = 1'b1; v = 1'b1; end
            3'b011: begin r = a << b[4:0]; c = 1'b1; v = 1'b1; end
            3'b100: begin r = a >> b[4:0]; c = 1'b1; v = 1'b1; end
            default: begin r = 32'd0; c = 1'b1; v = 1'b1; end
        endcase
        return {v, r[31], (r == 32'd0), c, r};
    endfunction

    assign {r_alu_overflow, r_alu_negative, r_alu_zero, r_alu_carry, r_alu_result} = alu_model(r_alu_a, r_alu_b, r_alu_op);
    assign {p_alu_overflow, p_alu_negative, p_alu_zero, p_alu_carry, p_alu_result} = alu_model(p_alu_a, p_alu_b, p_alu_op);

    alu_arbiter #(.PRIORITY_MODE(1'b0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(r_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(r_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(r_alu_a), .alu_b(r_alu_b), .alu_op(r_alu_op), .alu_result(r_alu_result),
        .alu_carry(r_alu_carry), .alu_zero(r_alu_zero), .alu_negative(r_alu_negative), .alu_overflow(r_alu_overflow),
        .rsp0_valid(r_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(r_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(r_rsp_result), .rsp_flags(r_rsp_flags), .busy(r_busy)
    );

    alu_arbiter #(.PRIORITY_MODE(1'b1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(p_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(p_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_op(p_alu_op), .alu_result(p_alu_result),
        .alu_carry(p_alu_carry), .alu_zero(p_alu_zero), .alu_negative(p_alu_negative), .alu_overflow(p_alu_overflow),
        .rsp0_valid(p_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(p_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(p_rsp_result), .rsp_flags(p_rsp_flags), .busy(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 32'd0; req0_b = 32'd0; req0_op = 3'b000;
        req1_a = 32'd0; req1_b = 32'd0; req1_op = 3'b000;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++; if (r_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", r_busy); end
        checks++; if ({r_rsp0_valid, r_rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", {r_rsp0_valid, r_rsp1_valid}); end
        checks++; if ({r_alu_a, r_alu_b, r_alu_op} !== 67'd0) begin errors++; $display("FAIL reset_alu got=%h/%h/%b exp=0", r_alu_a, r_alu_b, r_alu_op); end
        checks++; if ({r_rsp_result, r_rsp_flags} !== 36'd0) begin errors++; $display("FAIL reset_rsp got=%h/%b exp=0", r_rsp_result, r_rsp_flags); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_add();
        req0_valid = 1'b1; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req0_op = 3'b000; rsp0_ready = 1'b1;
        #1;
        checks++; if ({r_req0_ready, r_req1_ready} !== 2'b10) begin errors++; $display("FAIL add_ready got=%b exp=10", {r_req0_ready, r_req1_ready}); end
        step();
        req0_valid = 1'b0;
        checks++; if ({r_busy, r_rsp0_valid} !== 2'b10) begin errors++; $display("FAIL add_exec busy/valid got=%b exp=10", {r_busy, r_rsp0_valid}); end
        checks++; if ({r_alu_a, r_alu_b, r_alu_op} !== {32'hFFFF_FFFF, 32'd1, 3'b000}) begin errors++; $display("FAIL add_alu_regs got=%h/%h/%b", r_alu_a, r_alu_b, r_alu_op); end
        step();
        checks++; if ({r_rsp0_valid, r_rsp1_valid} !== 2'b10) begin errors++; $display("FAIL add_rsp_valid got=%b exp=10", {r_rsp0_valid, r_rsp1_valid}); end
        checks++; if (r_rsp_result !== 32'd0) begin errors++; $display("FAIL add_result got=%h exp=0", r_rsp_result); end
        checks++; if (r_rsp_flags !== 4'b0011) begin errors++; $display("FAIL add_flags got=%b exp=0011", r_rsp_flags); end
        step();
        checks++; if ({r_rsp0_valid, r_busy} !== 2'b00) begin errors++; $display("FAIL add_done got=%b exp=00", {r_rsp0_valid, r_busy}); end
        rsp0_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd5;    req0_b = 32'd3;    req0_op = 3'b001;
        req1_valid = 1'b1; req1_a = 32'hF0;   req1_b = 32'h3C;   req1_op = 3'b010;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic ep;
            ep = i[0];
            checks++; if ({r_req0_ready, r_req1_ready} !== {!ep, ep}) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", i, {r_req0_ready, r_req1_ready}, {!ep, ep}); end
            step();
            step();
            checks++; if ({r_rsp0_valid, r_rsp1_valid} !== {!ep, ep}) begin errors++; $display("FAIL rr_rsp_valid%0d got=%b exp=%b", i, {r_rsp0_valid, r_rsp1_valid}, {!ep, ep}); end
            checks++; if (r_rsp_result !== (ep ? 32'h30 : 32'd2)) begin errors++; $display("FAIL rr_result%0d got=%h exp=%h", i, r_rsp_result, ep ? 32'h30 : 32'd2); end
            checks++; if (r_rsp_flags !== 4'b0000) begin errors++; $display("FAIL rr_flags%0d got=%b exp=0000", i, r_rsp_flags); end
            checks++; if ({r_req0_ready, r_req1_ready} !== 2'b00) begin errors++; $display("FAIL rr_stall_ready%0d got=%b exp=00", i, {r_req0_ready, r_req1_ready}); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_fixed_priority();
        apply_reset();
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd20; req0_op = 3'b000;
        req1_valid = 1'b1; req1_a = 32'd1;  req1_b = 32'd1;  req1_op = 3'b001;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++; if ({p_req0_ready, p_req1_ready} !== 2'b10) begin errors++; $display("FAIL fp_grant%0d got=%b exp=10", i, {p_req0_ready, p_req1_ready}); end
            step();
            checks++; if (p_req1_ready !== 1'b0) begin errors++; $display("FAIL fp_req1_ready%0d got=%b exp=0", i, p_req1_ready); end
            step();
            checks++; if ({p_rsp0_valid, p_rsp1_valid} !== 2'b10) begin errors++; $display("FAIL fp_rsp_valid%0d got=%b exp=10", i, {p_rsp0_valid, p_rsp1_valid}); end
            checks++; if (p_rsp_result !== 32'd30) begin errors++; $display("FAIL fp_result%0d got=%h exp=1e", i, p_rsp_result); end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        apply_reset();
        req1_valid = 1'b1; req1_a = 32'd1; req1_b = 32'd31; req1_op = 3'b011;
        #1;
        checks++; if (r_req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready got=%b exp=1", r_req1_ready); end
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3; req0_op = 3'b000;
        rsp0_ready = 1'b1;
        #1;
        checks++; if (r_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_exec_req0_ready got=%b exp=0", r_req0_ready); end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if ({r_rsp1_valid, r_rsp0_valid} !== 2'b10) begin errors++; $display("FAIL bp_valid%0d got=%b exp=10", i, {r_rsp1_valid, r_rsp0_valid}); end
            checks++; if ({r_rsp_result, r_rsp_flags} !== {32'h8000_0000, 4'b0100}) begin errors++; $display("FAIL bp_hold%0d got=%h/%b exp=80000000/0100", i, r_rsp_result, r_rsp_flags); end
            checks++; if (r_req0_ready !== 1'b0) begin errors++; $display("FAIL bp_req0_ready%0d got=%b exp=0", i, r_req0_ready); end
            step();
        end
        rsp1_ready = 1'b1;
        #1;
        checks++; if ({r_rsp1_valid, r_req0_ready} !== 2'b10) begin errors++; $display("FAIL bp_handshake got=%b exp=10", {r_rsp1_valid, r_req0_ready}); end
        step();
        rsp1_ready = 1'b0;
        checks++; if ({r_rsp1_valid, r_req0_ready} !== 2'b01) begin errors++; $display("FAIL bp_resume got=%b exp=01", {r_rsp1_valid, r_req0_ready}); end
        step();
        req0_valid = 1'b0;
        step();
        checks++; if ({r_rsp0_valid, r_rsp_result, r_rsp_flags} !== {1'b1, 32'd5, 4'b0000}) begin errors++; $display("FAIL bp_next_op got=%b/%h/%b exp=1/5/0000", r_rsp0_valid, r_rsp_result, r_rsp_flags); end
        step();
        idle_inputs();
    endtask

    task automatic test_flag_mask();
        rsp0_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_op = 3'b010;
        step();
        req0_valid = 1'b0;
        step();
        checks++; if ({r_rsp_result, r_rsp_flags} !== {32'h8000_0000, 4'b0100}) begin errors++; $display("FAIL mask_and got=%h/%b exp=80000000/0100", r_rsp_result, r_rsp_flags); end
        step();
        req0_valid = 1'b1; req0_a = 32'h1234_5678; req0_b = 32'h0000_00FF; req0_op = 3'b111;
        step();
        req0_valid = 1'b0;
        checks++; if (r_alu_op !== 3'b111) begin errors++; $display("FAIL mask_op_fwd got=%b exp=111", r_alu_op); end
        step();
        checks++; if ({r_rsp_result, r_rsp_flags} !== {32'd0, 4'b0010}) begin errors++; $display("FAIL mask_op7 got=%h/%b exp=0/0010", r_rsp_result, r_rsp_flags); end
        step();
        idle_inputs();
    endtask

    task automatic test_reset_exec();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1; req0_op = 3'b000;
        step();
        req0_valid = 1'b0;
        checks++; if (r_busy !== 1'b1) begin errors++; $display("FAIL rst_exec_busy got=%b exp=1", r_busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({r_busy, r_rsp0_valid, r_rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_exec_drop got=%b exp=000", {r_busy, r_rsp0_valid, r_rsp1_valid}); end
        checks++; if ({r_alu_a, r_alu_op} !== 35'd0) begin errors++; $display("FAIL rst_exec_alu got=%h/%b exp=0", r_alu_a, r_alu_op); end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if ({r_rsp0_valid, r_rsp1_valid, r_busy} !== 3'b000) begin errors++; $display("FAIL rst_exec_quiet%0d got=%b exp=000", i, {r_rsp0_valid, r_rsp1_valid, r_busy}); end
        end
        req1_valid = 1'b1; req1_a = 32'd7; req1_b = 32'd8; req1_op = 3'b000;
        #1;
        checks++; if (r_req1_ready !== 1'b1) begin errors++; $display("FAIL rst_after_ready got=%b exp=1", r_req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        checks++; if ({r_rsp1_valid, r_rsp_result, r_rsp_flags} !== {1'b1, 32'd15, 4'b0000}) begin errors++; $display("FAIL rst_after_op got=%b/%h/%b exp=1/f/0000", r_rsp1_valid, r_rsp_result, r_rsp_flags); end
        step();
        checks++; if ({r_rsp1_valid, r_busy} !== 2'b00) begin errors++; $display("FAIL rst_after_done got=%b exp=00", {r_rsp1_valid, r_busy}); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_flag_mask();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
